config_chain_loader: RTL
========================

# config_chain_loader

Serializes a configuration bitstream into a logic tile's serial configuration shift chain. Accepts parallel words from the bitstream source over a valid/ready handshake and drives the chain's serial data and shift-enable inputs, one bit per clock, MSB of each word first, for exactly CHAIN_LENGTH shifts. Sits between the bitstream fetch/host interface and each tile's configuration register chain, in the same clock domain as the chain.

## Interface

- CHAIN_LENGTH, 524: number of bits in the target configuration chain; exact number of shift cycles per load.
- WORD_WIDTH, 32: width of input words; must be ≥ 2.
- clock  input  1  rising-edge clock, shared with the configuration chain.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a load; honoured only in IDLE.
- abort  input  1  terminates a load in progress; sampled in FETCH and SHIFT.
- word_data  input  WORD_WIDTH  bitstream word; bit WORD_WIDTH-1 is shifted first.
- word_valid  input  1  word_data is valid.
- word_ready  output  1  loader accepts a word this cycle (valid && ready = transfer).
- config_data  output  1  serial bit to the chain's data input, registered.
- config_enable  output  1  chain shift enable, registered; high for exactly one cycle per shifted bit.
- busy  output  1  high from the cycle after start is accepted until the cycle before done returns to IDLE.
- done  output  1  single-cycle pulse: CHAIN_LENGTH bits were shifted.
- aborted  output  1  single-cycle pulse: the load was terminated by abort.

## Operation

- Words required: NWORDS = ceil(CHAIN_LENGTH / WORD_WIDTH). The last word contributes LAST = CHAIN_LENGTH − (NWORDS−1)·WORD_WIDTH bits, taken from its MSBs; its remaining low bits are discarded. Default: 17 words, last word uses bits [31:20].
- Bit ordering: the first bit shifted ends at the chain MSB. For the defaults, chain bit 523 = word0[31] and chain bit 0 = word16[20].
- State IDLE: word_ready=0, config_enable=0, busy=0. If start=1, go to FETCH. abort is ignored in IDLE.
- State FETCH: word_ready=1, config_enable=0. On word_valid=1, load word_data into the shift register, load the word bit counter with WORD_WIDTH (or LAST for the final word), and go to SHIFT.
- State SHIFT: word_ready=0. Each cycle: config_enable=1, config_data=shift_reg MSB, shift the register left, decrement the word bit counter and total bit counter.
  - When the word bit counter expires and total bits remain, go to FETCH.
  - When the total reaches CHAIN_LENGTH, go to DONE.
- State DONE: done=1 for one cycle, config_enable=0, then return to IDLE.
- abort=1 in FETCH or SHIFT: go to IDLE and pulse aborted=1 in the same transition cycle. config_enable drops with that edge. Bits already shifted remain in the chain. Abort has priority over a simultaneous word handshake and over the final shift.
- start while busy: ignored; it does not restart or extend the load.
- Counters: the total bit counter is clog2(CHAIN_LENGTH+1) bits wide, and the word bit counter is clog2(WORD_WIDTH+1) bits wide. No wrap-around is permitted; the total count never exceeds CHAIN_LENGTH.

## Timing

- Reset values (asynchronous, immediate on reset assertion): state=IDLE, word_ready=0, config_data=0, config_enable=0, busy=0, done=0, aborted=0, counters=0, shift register=0.
- Reset mid-load: outputs clear immediately and no further shifts occur. The chain keeps whatever it holds; the bitstream source must restart from word0.
- start accepted at edge N: word_ready=1 during cycle N+1.
- Word transfer at edge M: config_enable=1 with the word's MSB during cycle M+1. A full word then shifts over cycles M+1..M+WORD_WIDTH, and word_ready reasserts in cycle M+WORD_WIDTH+1.
- Total load latency with word_valid held high: NWORDS fetch cycles + CHAIN_LENGTH shift cycles. For the defaults, 17 + 524 = 541 cycles from the first FETCH cycle to the DONE cycle.
- config_enable is never high in two non-SHIFT cycles. Source stalls (word_valid=0) insert config_enable=0 gaps and lose no bits.

## Test plan

- Default parameters, word_valid held high, word k = 32'hA5000000 + k: config_enable is high for exactly 524 cycles. A chain model shows bit 523 = 1 (word0[31]) and bit 0 = word16[20]. done pulses once, 541 cycles after the first FETCH cycle.
- Random word_valid stalls (30% duty) during the same load: the final chain contents are identical to the no-stall case. config_enable is never high while in FETCH, and exactly 17 handshakes occur.
- CHAIN_LENGTH=64, WORD_WIDTH=32, words 32'hFFFF0000 and 32'h0000FFFF: exactly 2 handshakes and 64 shifts, and the chain reads 64'hFFFF00000000FFFF.
- Pulse start at cycle 5 of SHIFT, then assert abort with the 10th word's handshake: start has no effect, aborted pulses once, and done never pulses. The word is not accepted, and the state returns to IDLE with config_enable=0 on the next cycle.
- Assert reset asynchronously mid-SHIFT, between clock edges: config_enable, busy, and word_ready go to 0 before the next edge. After release and a new start, a full load completes correctly.

Source files
------------

// File: rtl/config_chain_loader_if.sv
// -----------------------------------------------------------------------------
// config_chain_loader_if
// Word handshake between the bitstream source and the configuration loader.
//
// Signals:
//   wordData  - bitstream word, bit WORD_WIDTH-1 is shifted into the chain first
//   wordValid - source has a word on wordData
//   wordReady - loader takes the word this cycle (wordValid && wordReady = transfer)
//
// Modports:
//   master - bitstream source (drives data/valid, observes ready)
//   slave  - loader (observes data/valid, drives ready)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface config_chain_loader_if #(
  parameter int WORD_WIDTH = 32
);
  logic [WORD_WIDTH-1:0] wordData;
  logic                  wordValid;
  logic                  wordReady;

  modport master (
    output wordData,
    output wordValid,
    input  wordReady
  );

  modport slave (
    input  wordData,
    input  wordValid,
    output wordReady
  );
endinterface

// File: rtl/config_chain_loader.sv
// -----------------------------------------------------------------------------
// config_chain_loader
// Streams a configuration bitstream into a tile's serial configuration chain.
// Parallel words arrive over a valid/ready handshake and are shifted out one
// bit per clock, MSB of each word first, for exactly CHAIN_LENGTH shifts. The
// final word only contributes as many high bits as are still needed; its low
// bits are dropped.
//
// Ports:
//   clk             - rising-edge clock, shared with the configuration chain
//   rst             - asynchronous active-high reset
//   start_i         - single-cycle load request, honoured only when idle
//   abort_i         - terminates a load while fetching or shifting
//   wordBus         - word handshake (slave side)
//   configData_o    - registered serial data to the chain
//   configEnable_o  - registered chain shift enable, one cycle per bit
//   busy_o          - a load is in progress (through the done cycle)
//   done_o          - one-cycle pulse: CHAIN_LENGTH bits have been shifted
//   aborted_o       - one-cycle pulse: the load was terminated by abort_i
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module config_chain_loader #(
  parameter int CHAIN_LENGTH = 524,
  parameter int WORD_WIDTH   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                abort_i,
  config_chain_loader_if.slave wordBus,
  output logic                configData_o,
  output logic                configEnable_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                aborted_o
);

  localparam int TOTAL_W = $clog2(CHAIN_LENGTH + 1);
  localparam int WCNT_W  = $clog2(WORD_WIDTH + 1);

  localparam logic [TOTAL_W-1:0] CHAIN_LEN_C  = TOTAL_W'(CHAIN_LENGTH);
  localparam logic [31:0]        WORD_WIDTH_C = 32'(WORD_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    DONE
  } state_t;

  state_t                state_q;
  logic [WORD_WIDTH-1:0] shiftReg_q;
  logic [WCNT_W-1:0]     wordCnt_q;
  logic [TOTAL_W-1:0]    totalCnt_q;
  logic                  wordReady_q;
  logic                  configData_q;
  logic                  configEnable_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  aborted_q;

  logic [TOTAL_W-1:0]    remaining;
  logic [WCNT_W-1:0]     fetchLen;

  // Bits the next fetched word contributes: a full word while more than a
  // word's worth of chain remains, otherwise only the leftover high bits.
  always_comb begin
    remaining = CHAIN_LEN_C - totalCnt_q;
    if (32'(remaining) >= WORD_WIDTH_C) begin
      fetchLen = WCNT_W'(WORD_WIDTH);
    end else begin
      fetchLen = WCNT_W'(remaining);
    end
  end

  // Load sequencer. wordCnt_q holds the bits of the current word that have
  // not yet been presented on configData_q, so the word's first bit goes out
  // in the cycle right after the handshake and the word is finished when
  // the counter is zero. totalCnt_q counts bits presented to the chain and
  // stops exactly at CHAIN_LENGTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      shiftReg_q     <= '0;
      wordCnt_q      <= '0;
      totalCnt_q     <= '0;
      wordReady_q    <= 1'b0;
      configData_q   <= 1'b0;
      configEnable_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      aborted_q      <= 1'b0;
    end else begin
      configEnable_q <= 1'b0;
      done_q         <= 1'b0;
      aborted_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q     <= FETCH;
            wordReady_q <= 1'b1;
            busy_q      <= 1'b1;
            totalCnt_q  <= '0;
            wordCnt_q   <= '0;
          end
        end
        FETCH: begin
          // Abort wins over a word offered in the same cycle.
          if (abort_i) begin
            state_q     <= IDLE;
            wordReady_q <= 1'b0;
            busy_q      <= 1'b0;
            aborted_q   <= 1'b1;
          end else if (wordBus.wordValid) begin
            state_q        <= SHIFT;
            wordReady_q    <= 1'b0;
            configEnable_q <= 1'b1;
            configData_q   <= wordBus.wordData[WORD_WIDTH-1];
            shiftReg_q     <= {wordBus.wordData[WORD_WIDTH-2:0], 1'b0};
            wordCnt_q      <= fetchLen - WCNT_W'(1);
            totalCnt_q     <= totalCnt_q + TOTAL_W'(1);
          end
        end
        SHIFT: begin
          if (abort_i) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
          end else if (wordCnt_q != '0) begin
            configEnable_q <= 1'b1;
            configData_q   <= shiftReg_q[WORD_WIDTH-1];
            shiftReg_q     <= {shiftReg_q[WORD_WIDTH-2:0], 1'b0};
            wordCnt_q      <= wordCnt_q - WCNT_W'(1);
            totalCnt_q     <= totalCnt_q + TOTAL_W'(1);
          end else if (totalCnt_q == CHAIN_LEN_C) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q     <= FETCH;
            wordReady_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          wordReady_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Ready is masked by abort so the source never sees a transfer that the
  // loader is about to discard.
  assign wordBus.wordReady = wordReady_q & ~abort_i;
  assign configData_o      = configData_q;
  assign configEnable_o    = configEnable_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign aborted_o         = aborted_q;

endmodule
